// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Bundles the control-master and count-consumer signals of
//   counter_sequencer. WIDTH/SWEEP_W must match the attached sequencer.
//   master : drives cfg_valid/cfg_lo/cfg_hi/cfg_mode/cfg_sweeps, start, stop,
//            pause; observes cfg_ready, cfg_err, cont, dir, busy, wrap, done.
//   slave  : the sequencer side (directions reversed).
interface counter_sequencer_if #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned SWEEP_W = 8
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [WIDTH-1:0]   cfg_lo;
   logic [WIDTH-1:0]   cfg_hi;
   logic [1:0]         cfg_mode;
   logic [SWEEP_W-1:0] cfg_sweeps;
   logic               cfg_err;
   logic               start;
   logic               stop;
   logic               pause;
   logic [WIDTH-1:0]   cont;
   logic               dir;
   logic               busy;
   logic               wrap;
   logic               done;

   modport master (
      output cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_sweeps, start, stop, pause,
      input  cfg_ready, cfg_err, cont, dir, busy, wrap, done
   );

   modport slave (
      input  cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_sweeps, start, stop, pause,
      output cfg_ready, cfg_err, cont, dir, busy, wrap, done
   );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Programmable up/down sweep counter controller. Holds a configuration
//   (lo/hi bounds, mode, sweep count), runs the count on start, aborts on
//   stop and pulses done after the configured number of endpoint events.
//   Modes: 00 up-wrap, 01 down-wrap, 10 bounce, 11 rejected.
//   Optional feature macro: SEQ_PAUSE_EN (builds the PAUSE state; otherwise
//   the pause input is ignored).
// Ports
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : counter_sequencer_if.slave (config handshake, start/stop/pause,
//           cont/dir/busy/wrap/done status); all outputs registered
module counter_sequencer #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned SWEEP_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   counter_sequencer_if.slave bus
);

`ifdef SEQ_PAUSE_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BAD    = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
   localparam logic [SWEEP_W-1:0] ONE_S = SWEEP_W'(1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_cont;
   logic               r_dir;
   logic               r_busy;
   logic               r_wrap;
   logic               r_done;
   logic               r_cfg_err;
   logic               r_cfg_ready;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi;
   mode_t              r_mode;
   logic [SWEEP_W-1:0] r_sweeps;
   logic [SWEEP_W-1:0] r_sweep_cnt;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_cont_nxt;
   logic               w_dir_nxt;
   logic               w_busy_nxt;
   logic               w_wrap_nxt;
   logic               w_done_nxt;
   logic               w_cfg_err_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic [WIDTH-1:0]   w_hi_nxt;
   mode_t              w_mode_nxt;
   logic [SWEEP_W-1:0] w_sweeps_nxt;
   logic [SWEEP_W-1:0] w_sweep_cnt_nxt;

   logic               w_cfg_hs;
   logic               w_cfg_bad;
   logic [WIDTH-1:0]   w_step_cont;
   logic               w_step_dir;
   logic               w_event;
   logic [SWEEP_W-1:0] w_sweep_inc;
   logic               w_last;

`ifndef SEQ_PAUSE_EN
   logic w_unused_pause;
   assign w_unused_pause = bus.pause;
`endif

   assign w_cfg_hs  = bus.cfg_valid && r_cfg_ready;
   assign w_cfg_bad = (bus.cfg_lo >= bus.cfg_hi) || (bus.cfg_mode == MODE_BAD);

   // Candidate single step from the current count, independent of state.
   always_comb begin
      w_step_cont = r_cont;
      w_step_dir  = r_dir;
      w_event     = 1'b0;
      unique case (r_mode)
         MODE_UP: begin
            if (r_cont == r_hi) begin
               w_event     = 1'b1;
               w_step_cont = r_lo;
            end else begin
               w_step_cont = r_cont + ONE_W;
            end
         end
         MODE_DOWN: begin
            if (r_cont == r_lo) begin
               w_event     = 1'b1;
               w_step_cont = r_hi;
            end else begin
               w_step_cont = r_cont - ONE_W;
            end
         end
         default: begin
            // Bounce turns around at the endpoint in the same step, so the
            // endpoint value is shown once per pass.
            if (!r_dir) begin
               if (r_cont == r_hi) begin
                  w_event     = 1'b1;
                  w_step_dir  = 1'b1;
                  w_step_cont = r_hi - ONE_W;
               end else begin
                  w_step_cont = r_cont + ONE_W;
               end
            end else begin
               if (r_cont == r_lo) begin
                  w_event     = 1'b1;
                  w_step_dir  = 1'b0;
                  w_step_cont = r_lo + ONE_W;
               end else begin
                  w_step_cont = r_cont - ONE_W;
               end
            end
         end
      endcase
      w_sweep_inc = r_sweep_cnt + ONE_S;
      w_last      = w_event && (r_sweeps != '0) && (w_sweep_inc == r_sweeps);
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cont_nxt      = r_cont;
      w_dir_nxt       = r_dir;
      w_wrap_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      w_cfg_err_nxt   = 1'b0;
      w_lo_nxt        = r_lo;
      w_hi_nxt        = r_hi;
      w_mode_nxt      = r_mode;
      w_sweeps_nxt    = r_sweeps;
      w_sweep_cnt_nxt = r_sweep_cnt;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_cfg_hs) begin
               if (w_cfg_bad) begin
                  w_cfg_err_nxt = 1'b1;
               end else begin
                  w_lo_nxt     = bus.cfg_lo;
                  w_hi_nxt     = bus.cfg_hi;
                  w_mode_nxt   = mode_t'(bus.cfg_mode);
                  w_sweeps_nxt = bus.cfg_sweeps;
               end
            end else if (bus.start) begin
               w_state_nxt     = S_RUN;
               w_sweep_cnt_nxt = '0;
               if (r_mode == MODE_DOWN) begin
                  w_cont_nxt = r_hi;
                  w_dir_nxt  = 1'b1;
               end else begin
                  w_cont_nxt = r_lo;
                  w_dir_nxt  = 1'b0;
               end
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
`ifdef SEQ_PAUSE_EN
            end else if (bus.pause) begin
               w_state_nxt = S_PAUSE;
`endif
            end else begin
               if (w_event) begin
                  w_wrap_nxt      = 1'b1;
                  w_sweep_cnt_nxt = w_sweep_inc;
               end
               if (w_last) begin
                  // Final event: hold at the endpoint instead of stepping.
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_cont_nxt = w_step_cont;
                  w_dir_nxt  = w_step_dir;
               end
            end
         end
`ifdef SEQ_PAUSE_EN
         S_PAUSE: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
            end else if (!bus.pause) begin
               w_state_nxt = S_RUN;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_RUN);
`ifdef SEQ_PAUSE_EN
      w_busy_nxt = w_busy_nxt || (w_state_nxt == S_PAUSE);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cont      <= '0;
         r_dir       <= 1'b0;
         r_busy      <= 1'b0;
         r_wrap      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_lo        <= '0;
         r_hi        <= '1;
         r_mode      <= MODE_BOUNCE;
         r_sweeps    <= '0;
         r_sweep_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cont      <= w_cont_nxt;
         r_dir       <= w_dir_nxt;
         r_busy      <= w_busy_nxt;
         r_wrap      <= w_wrap_nxt;
         r_done      <= w_done_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
         r_cfg_ready <= !w_busy_nxt;
         r_lo        <= w_lo_nxt;
         r_hi        <= w_hi_nxt;
         r_mode      <= w_mode_nxt;
         r_sweeps    <= w_sweeps_nxt;
         r_sweep_cnt <= w_sweep_cnt_nxt;
      end
   end

   assign bus.cont      = r_cont;
   assign bus.dir       = r_dir;
   assign bus.busy      = r_busy;
   assign bus.wrap      = r_wrap;
   assign bus.done      = r_done;
   assign bus.cfg_err   = r_cfg_err;
   assign bus.cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Scoreboard bench for counter_sequencer. The driver applies inputs at the
//   falling edge, advances a trajectory-based reference model and queues the
//   outputs expected after the next rising edge; the monitor pops and
//   compares after every rising edge.
module tb_counter_sequencer;
   localparam int unsigned WIDTH   = 4;
   localparam int unsigned SWEEP_W = 8;

   typedef struct {
      logic [WIDTH-1:0] cont;
      logic             dir;
      logic             busy;
      logic             wrap;
      logic             done;
      logic             rdy;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   counter_sequencer_if #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) bus ();

   counter_sequencer #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a run is a position index along a periodic trajectory.
   int m_lo, m_hi, m_mode, m_sweeps, m_pos, m_events, m_cont;
   bit m_busy, m_paused, m_dir;

   function automatic void traj(input int mode, input int lo, input int hi, input int pos,
                                output int c, output bit d, output bit ev);
      int span, m;
      span = hi - lo;
      if (mode == 0) begin
         m = pos % (span + 1);
         c = lo + m; d = 1'b0; ev = (m == span);
      end else if (mode == 1) begin
         m = pos % (span + 1);
         c = hi - m; d = 1'b1; ev = (m == span);
      end else begin
         m = pos % (2 * span);
         c = lo + ((m <= span) ? m : 2 * span - m);
         d = (m > span) || (m == 0 && pos > 0);
         ev = (m == span) || (m == 0 && pos > 0);
      end
   endfunction

   task automatic model_reset();
      m_lo = 0; m_hi = (1 << WIDTH) - 1; m_mode = 2; m_sweeps = 0;
      m_pos = 0; m_events = 0; m_cont = 0; m_dir = 1'b0;
      m_busy = 1'b0; m_paused = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      int   c;
      bit   d, ev;
      bit   wrap_x, done_x, err_x;
      wrap_x = 1'b0; done_x = 1'b0; err_x = 1'b0;
      if (reset) begin
         model_reset();
      end else if (!m_busy) begin
         if (bus.cfg_valid) begin
            if (bus.cfg_lo >= bus.cfg_hi || bus.cfg_mode == 2'b11) begin
               err_x = 1'b1;
            end else begin
               m_lo = int'(bus.cfg_lo); m_hi = int'(bus.cfg_hi);
               m_mode = int'(bus.cfg_mode); m_sweeps = int'(bus.cfg_sweeps);
            end
         end else if (bus.start) begin
            m_busy = 1'b1; m_paused = 1'b0; m_pos = 0; m_events = 0;
            traj(m_mode, m_lo, m_hi, m_pos, c, d, ev);
            m_cont = c; m_dir = d;
         end
      end else if (bus.stop) begin
         m_busy = 1'b0; m_paused = 1'b0;
`ifdef SEQ_PAUSE_EN
      end else if (m_paused) begin
         if (!bus.pause) m_paused = 1'b0;
      end else if (bus.pause) begin
         m_paused = 1'b1;
`endif
      end else begin
         traj(m_mode, m_lo, m_hi, m_pos, c, d, ev);
         if (ev) begin
            m_events++;
            wrap_x = 1'b1;
         end
         if (ev && m_sweeps != 0 && m_events == m_sweeps) begin
            m_busy = 1'b0; done_x = 1'b1;
         end else begin
            m_pos++;
            traj(m_mode, m_lo, m_hi, m_pos, c, d, ev);
            m_cont = c; m_dir = d;
         end
      end
      e.cont = m_cont[WIDTH-1:0];
      e.dir  = m_dir;
      e.busy = m_busy;
      e.wrap = wrap_x;
      e.done = done_x;
      e.rdy  = !m_busy;
      e.err  = err_x;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle_in();
      bus.cfg_valid = 1'b0; bus.cfg_lo = '0; bus.cfg_hi = '0; bus.cfg_mode = 2'b00;
      bus.cfg_sweeps = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
   endtask

   task automatic cfg(input int lo, input int hi, input int mode, input int sw);
      bus.cfg_valid = 1'b1; bus.cfg_lo = WIDTH'(lo); bus.cfg_hi = WIDTH'(hi);
      bus.cfg_mode = 2'(mode); bus.cfg_sweeps = SWEEP_W'(sw);
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares every queued expectation after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cont",      int'(bus.cont),      int'(e.cont));
            chk("dir",       int'(bus.dir),       int'(e.dir));
            chk("busy",      int'(bus.busy),      int'(e.busy));
            chk("wrap",      int'(bus.wrap),      int'(e.wrap));
            chk("done",      int'(bus.done),      int'(e.done));
            chk("cfg_ready", int'(bus.cfg_ready), int'(e.rdy));
            chk("cfg_err",   int'(bus.cfg_err),   int'(e.err));
         end
      end
   end

   initial begin
      int r, lo, hi, mode;
      idle_in();
      model_reset();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(1);

      // Default bounce 0..15..0, never done.
      pulse_start();
      run(40);
      pulse_stop();

      // Bounce 2..5 with two sweeps.
      cfg(2, 5, 2, 2);
      pulse_start();
      run(10);

      // Up-wrap forever.
      cfg(0, 15, 0, 0);
      pulse_start();
      run(40);
      pulse_stop();

      // Rejected configs, then a run on the previous config.
      cfg(7, 3, 0, 1);
      cfg(1, 9, 3, 1);
      pulse_start();
      run(4);
      cfg(3, 4, 1, 1);
      run(4);
      pulse_stop();

      // Stop at 9, then start+valid config together.
      pulse_start();
      for (int i = 0; i < 20 && m_cont != 9; i++) tick();
      pulse_stop();
      run(2);
      bus.start = 1'b1;
      cfg(4, 6, 1, 1);
      bus.start = 1'b0;
      run(3);
      pulse_start();
      run(5);

      // Pause for 5 cycles at cont=4 in up-wrap.
      cfg(0, 15, 0, 0);
      pulse_start();
      for (int i = 0; i < 20 && m_cont != 4; i++) tick();
      bus.pause = 1'b1;
      run(5);
      bus.pause = 1'b0;
      run(4);
      pulse_stop();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         idle_in();
         r = int'($urandom_range(0, 199));
         reset = (r == 0);
         if (r >= 1 && r < 16) begin
            lo = int'($urandom_range(0, 15));
            hi = int'($urandom_range(0, 15));
            mode = int'($urandom_range(0, 3));
            bus.cfg_valid = 1'b1; bus.cfg_lo = WIDTH'(lo); bus.cfg_hi = WIDTH'(hi);
            bus.cfg_mode = 2'(mode); bus.cfg_sweeps = SWEEP_W'($urandom_range(0, 4));
            bus.start = (lo < hi && mode != 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         end else if (r >= 16 && r < 36) begin
            bus.start = 1'b1;
         end else if (r >= 36 && r < 42) begin
            bus.stop = 1'b1;
         end else if (r >= 42 && r < 60) begin
            bus.pause = 1'b1;
         end
         tick();
      end
      reset = 1'b0;
      idle_in();
      run(2);

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
